// File: rtl/serial_mag_compare_ctrl.sv
// Serial unsigned magnitude compare, two bits per clock, MSB first.
// Start/busy/done handshake with optional exit on the first unequal slice.
module serial_mag_compare_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1,
    parameter int CW         = $clog2(WIDTH / 2) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic [CW-1:0]    slices
);

    localparam int NS = WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    k_q, k_d;
    logic [CW-1:0]    slices_q, slices_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             decided_q, decided_d;

    logic a1, a0, b1, b0;
    logic gt_s, lt_s, eq_s;
    logic last_k;

    assign a1 = a_q[WIDTH-1];
    assign a0 = a_q[WIDTH-2];
    assign b1 = b_q[WIDTH-1];
    assign b0 = b_q[WIDTH-2];

    assign gt_s   = (a1 & ~b1) | ((a1 ~^ b1) & a0 & ~b0);
    assign lt_s   = (~a1 & b1) | ((a1 ~^ b1) & ~a0 & b0);
    assign eq_s   = (a1 ~^ b1) & (a0 ~^ b0);
    assign last_k = (k_q == CW'(NS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            k_q       <= '0;
            slices_q  <= '0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            decided_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            k_q       <= k_d;
            slices_q  <= slices_d;
            gt_q      <= gt_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            decided_q <= decided_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        k_d       = k_q;
        slices_d  = slices_q;
        gt_d      = gt_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        decided_d = decided_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    k_d       = '0;
                    slices_d  = '0;
                    gt_d      = 1'b0;
                    eq_d      = 1'b0;
                    lt_d      = 1'b0;
                    decided_d = 1'b0;
                    state_d   = COMPARE;
                end
            end
            COMPARE: begin
                // only the first unequal slice may set the result
                if (!eq_s && !decided_q) begin
                    gt_d      = gt_s;
                    lt_d      = lt_s;
                    slices_d  = k_q + CW'(1);
                    decided_d = 1'b1;
                end
                a_d = a_q << 2;
                b_d = b_q << 2;
                k_d = k_q + CW'(1);
                if ((EARLY_EXIT && !eq_s) || last_k) begin
                    state_d = DONE;
                    if (!decided_q && eq_s) begin
                        eq_d     = 1'b1;
                        slices_d = CW'(NS);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign a_gt_b = gt_q;
    assign a_eq_b = eq_q;
    assign a_lt_b = lt_q;
    assign slices = slices_q;

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Bench for serial_mag_compare_ctrl: W8 and W16 with both exit modes, W2.
// Expected results are queued at drive time and checked when done pulses.
module tb_serial_mag_compare_ctrl;

    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        int   sl;
        int   lat;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        exp_t       e1;
        exp_t       e0;
    } vec8_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  a8 = '0, b8 = '0;
    logic        st8 = 1'b0;
    logic [1:0]  a2 = '0, b2 = '0;
    logic        st2 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        st16 = 1'b0;

    logic [4:0] bz, dn, gt, eq, lt;
    logic [2:0] sl0, sl1;
    logic [0:0] sl2;
    logic [3:0] sl3, sl4;
    int         slv [5];

    always_comb begin
        slv[0] = int'(sl0);
        slv[1] = int'(sl1);
        slv[2] = int'(sl2);
        slv[3] = int'(sl3);
        slv[4] = int'(sl4);
    end

    serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
        .busy(bz[0]), .done(dn[0]), .a_gt_b(gt[0]), .a_eq_b(eq[0]),
        .a_lt_b(lt[0]), .slices(sl0));
    serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
        .busy(bz[1]), .done(dn[1]), .a_gt_b(gt[1]), .a_eq_b(eq[1]),
        .a_lt_b(lt[1]), .slices(sl1));
    serial_mag_compare_ctrl #(.WIDTH(2), .EARLY_EXIT(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2),
        .busy(bz[2]), .done(dn[2]), .a_gt_b(gt[2]), .a_eq_b(eq[2]),
        .a_lt_b(lt[2]), .slices(sl2));
    serial_mag_compare_ctrl #(.WIDTH(16), .EARLY_EXIT(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16),
        .busy(bz[3]), .done(dn[3]), .a_gt_b(gt[3]), .a_eq_b(eq[3]),
        .a_lt_b(lt[3]), .slices(sl3));
    serial_mag_compare_ctrl #(.WIDTH(16), .EARLY_EXIT(1'b0)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16),
        .busy(bz[4]), .done(dn[4]), .a_gt_b(gt[4]), .a_eq_b(eq[4]),
        .a_lt_b(lt[4]), .slices(sl4));

    exp_t q [5][$];
    exp_t last [5];
    bit   have_last [5];
    int   t0 [5];
    logic dn_prev [5];
    exp_t me;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input int f, input int sl, input int lat);
        exp_t r;
        r.gt  = (f == 0);
        r.eq  = (f == 1);
        r.lt  = (f == 2);
        r.sl  = sl;
        r.lat = lat;
        return r;
    endfunction

    function automatic vec8_t v8(input logic [7:0] a, input logic [7:0] b,
                                 input int f, input int sl,
                                 input int l1, input int l0);
        vec8_t v;
        v.a  = a;
        v.b  = b;
        v.e1 = mk(f, sl, l1);
        v.e0 = mk(f, sl, l0);
        return v;
    endfunction

    function automatic exp_t ref16(input logic [15:0] a, input logic [15:0] b,
                                   input bit ee);
        exp_t        r;
        logic [15:0] x;
        int          s;
        x = a ^ b;
        s = 8;
        for (int j = 7; j >= 0; j--)
            if (x[15-2*j -: 2] != 2'b00) s = j + 1;
        r.gt  = (a > b);
        r.eq  = (a == b);
        r.lt  = (a < b);
        r.sl  = s;
        r.lat = ee ? s : 8;
        return r;
    endfunction

    // scoreboard monitor for all five instances
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 5; i++) begin
                if (dn[i]) begin
                    cmp($sformatf("u%0d done_len", i), 32'(dn_prev[i]), 0);
                    cmp($sformatf("u%0d busy_in_done", i), 32'(bz[i]), 1);
                    if (q[i].size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL u%0d unexpected_done: got 1, required 0", i);
                    end else begin
                        me = q[i].pop_front();
                        cmp($sformatf("u%0d gt", i), 32'(gt[i]), 32'(me.gt));
                        cmp($sformatf("u%0d eq", i), 32'(eq[i]), 32'(me.eq));
                        cmp($sformatf("u%0d lt", i), 32'(lt[i]), 32'(me.lt));
                        cmp($sformatf("u%0d slices", i), slv[i], me.sl);
                        cmp($sformatf("u%0d latency", i), cyc - t0[i], me.lat);
                        last[i]      = me;
                        have_last[i] = 1'b1;
                    end
                end else if (!bz[i] && have_last[i]) begin
                    cmp($sformatf("u%0d hold", i),
                        {gt[i], eq[i], lt[i], 28'(slv[i])},
                        {last[i].gt, last[i].eq, last[i].lt, 28'(last[i].sl)});
                end
                dn_prev[i] = dn[i];
            end
        end
    end

    task automatic wait_idle(input logic [4:0] mask, input string nm);
        int n;
        n = 0;
        while ((bz & mask) != 5'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: busy=%b, required idle", nm, bz);
        end
    endtask

    task automatic run8(input vec8_t v);
        wait_idle(5'b00011, "w8");
        a8  = v.a;
        b8  = v.b;
        st8 = 1'b1;
        q[0].push_back(v.e1);
        q[1].push_back(v.e0);
        @(posedge clk);
        @(negedge clk);
        t0[0] = cyc;
        t0[1] = cyc;
        st8   = 1'b0;
        cmp("w8 accept_busy", 32'(bz[1:0]), 3);
        wait_idle(5'b00011, "w8");
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b);
        wait_idle(5'b11000, "w16");
        a16  = a;
        b16  = b;
        st16 = 1'b1;
        q[3].push_back(ref16(a, b, 1'b1));
        q[4].push_back(ref16(a, b, 1'b0));
        @(posedge clk);
        @(negedge clk);
        t0[3] = cyc;
        t0[4] = cyc;
        st16  = 1'b0;
        cmp("w16 accept_busy", 32'(bz[4:3]), 3);
        wait_idle(5'b11000, "w16");
    endtask

    task automatic clear_sb();
        for (int i = 0; i < 5; i++) begin
            q[i].delete();
            have_last[i] = 1'b0;
            dn_prev[i]   = 1'b0;
        end
    endtask

    vec8_t       tbl [10];
    logic [15:0] ra, rb;

    initial begin
        tbl[0] = v8(8'hA5, 8'hA5, 1, 4, 4, 4);
        tbl[1] = v8(8'h80, 8'h7F, 0, 1, 1, 4);
        tbl[2] = v8(8'h01, 8'h02, 2, 4, 4, 4);
        tbl[3] = v8(8'hC0, 8'h00, 0, 1, 1, 4);
        tbl[4] = v8(8'hC0, 8'h0F, 0, 1, 1, 4);
        tbl[5] = v8(8'h00, 8'hFF, 2, 1, 1, 4);
        tbl[6] = v8(8'h3C, 8'h30, 0, 3, 3, 4);
        tbl[7] = v8(8'hFF, 8'hFF, 1, 4, 4, 4);
        tbl[8] = v8(8'h00, 8'h00, 1, 4, 4, 4);
        tbl[9] = v8(8'h12, 8'h13, 2, 4, 4, 4);
        clear_sb();
        for (int i = 0; i < 5; i++) t0[i] = 0;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        cmp("rst busy", 32'(bz), 0);
        cmp("rst done", 32'(dn), 0);
        cmp("rst flags", {gt, eq, lt}, 0);
        for (int i = 0; i < 5; i++)
            cmp($sformatf("rst u%0d slices", i), slv[i], 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run8(tbl[i]);

        // start and operand changes while busy must be ignored
        wait_idle(5'b00011, "w8");
        a8  = 8'h55;
        b8  = 8'h56;
        st8 = 1'b1;
        q[0].push_back(mk(2, 4, 4));
        q[1].push_back(mk(2, 4, 4));
        @(posedge clk);
        @(negedge clk);
        t0[0] = cyc;
        t0[1] = cyc;
        a8    = 8'hFF;
        b8    = 8'h00;
        repeat (2) @(negedge clk);
        st8 = 1'b0;
        wait_idle(5'b00011, "w8 busy_start");

        // asynchronous reset in the middle of a compare
        a8  = 8'h00;
        b8  = 8'h00;
        st8 = 1'b1;
        q[0].push_back(mk(1, 4, 4));
        q[1].push_back(mk(1, 4, 4));
        @(posedge clk);
        @(negedge clk);
        t0[0] = cyc;
        t0[1] = cyc;
        st8   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        cmp("midrst busy", 32'(bz[1:0]), 0);
        cmp("midrst done", 32'(dn[1:0]), 0);
        cmp("midrst flags", {gt[1:0], eq[1:0], lt[1:0]}, 0);
        cmp("midrst slices", {16'(slv[0]), 16'(slv[1])}, 0);
        clear_sb();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run8(tbl[1]);
        run8(tbl[2]);

        // WIDTH=2 with start held high: one compare per three cycles
        wait_idle(5'b00100, "w2");
        st2 = 1'b1;
        for (int p = 0; p < 16; p++) begin
            a2 = 2'(p >> 2);
            b2 = 2'(p);
            q[2].push_back(mk((a2 > b2) ? 0 : ((a2 == b2) ? 1 : 2), 1, 1));
            @(posedge clk);
            @(negedge clk);
            t0[2] = cyc;
            cmp("w2 accept_busy", 32'(bz[2]), 1);
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
        end
        st2 = 1'b0;
        wait_idle(5'b00100, "w2");

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (16'h1 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            run16(ra, rb);
        end
        run16(16'hFFFF, 16'h0000);
        run16(16'h0001, 16'h0000);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++)
            cmp($sformatf("u%0d pending", i), q[i].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
